// File: rtl/interpolate_upsample.sv
// -----------------------------------------------------------------------------
// interpolate_upsample
//
// Rebuilds a full-rate signed sample stream from decimated block sums. Every
// data_valid_i strobe carries S, the sum of N = 2**LOG2_INTERP_FACTOR raw
// samples. The block emits one output sample per clock once it is running.
//
// Build option (macro INTERP_UPSAMPLE_LINEAR_EN):
//   defined   : linear interpolation. An accumulator walks from S_prev*N toward
//               S_curr*N in N steps, so y_k = floor((S_prev*N + k*(S_curr-S_prev)) / N^2).
//               Early and late strobes are flagged on timing_err_o.
//   undefined : zero-order hold. y = floor(S_curr/N); timing_err_o is tied low.
//
// Ports
//   clk_i          rising-edge clock
//   rst_i          asynchronous, active-high reset
//   data_valid_i   one-cycle strobe qualifying data_i
//   data_i         signed block sum S (INPUT_WIDTH bits)
//   data_valid_o   high on every cycle data_o is meaningful
//   data_o         signed, registered full-rate output (OUTPUT_WIDTH bits)
//   sat_o          high alongside a data_o value that was clipped
//   timing_err_o   sticky: a strobe arrived early or late (linear mode only)
// -----------------------------------------------------------------------------
module interpolate_upsample #(
    parameter int INPUT_WIDTH        = 19,
    parameter int LOG2_INTERP_FACTOR = 5,
    parameter int OUTPUT_WIDTH       = 14
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           data_valid_i,
    input  logic signed [INPUT_WIDTH-1:0]  data_i,
    output logic                           data_valid_o,
    output logic signed [OUTPUT_WIDTH-1:0] data_o,
    output logic                           sat_o,
    output logic                           timing_err_o
);
    localparam int IW = INPUT_WIDTH;
    localparam int L  = LOG2_INTERP_FACTOR;
    localparam int OW = OUTPUT_WIDTH;
    localparam int AW = IW + L + 1;

    // Output range expressed at the pre-saturation width.
    localparam logic signed [AW-1:0] Y_MAX = (AW'(1) <<< (OW - 1)) - AW'(1);
    localparam logic signed [AW-1:0] Y_MIN = ~Y_MAX;

    typedef enum logic [1:0] {
        ST_EMPTY  = 2'd0,
        ST_PRIMED = 2'd1,
        ST_RUN    = 2'd2
    } state_t;

`ifdef INTERP_UPSAMPLE_LINEAR_EN
    // Interpolation needs two samples before it has a segment to walk.
    localparam state_t ST_AFTER_FIRST = ST_PRIMED;
`else
    // Hold mode can output as soon as one sample is known.
    localparam state_t ST_AFTER_FIRST = ST_RUN;
`endif

    state_t state_q, state_d;
    logic   run;

    logic signed [IW-1:0] s_curr_q;
    logic signed [AW-1:0] pre_y;
    logic signed [OW-1:0] y_sat;
    logic                 clip;

    logic signed [OW-1:0] data_q;
    logic                 data_valid_q;
    logic                 sat_q;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY:  if (data_valid_i) state_d = ST_AFTER_FIRST;
            ST_PRIMED: if (data_valid_i) state_d = ST_RUN;
            ST_RUN:    state_d = ST_RUN;
            default:   state_d = ST_EMPTY;
        endcase
    end

    always_comb begin
        run = (state_q == ST_RUN);
    end

    // ------------------------------------------------------- sample store
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s_curr_q <= '0;
        end else if (data_valid_i) begin
            s_curr_q <= data_i;
        end
    end

`ifdef INTERP_UPSAMPLE_LINEAR_EN
    localparam int SW = IW + 1;
    localparam logic [L-1:0] K_LAST = '1;

    logic signed [IW-1:0] s_prev_q;
    logic signed [AW-1:0] acc_q, acc_d;
    logic signed [SW-1:0] step_q, step_d;
    logic [L-1:0]         k_q, k_d;
    logic                 timing_err_q, timing_err_d;

    // A strobe always restarts the segment from the outgoing S_curr; between
    // strobes the accumulator advances until the last phase, then freezes so
    // a missing strobe repeats the final point instead of extrapolating.
    always_comb begin
        acc_d  = acc_q;
        step_d = step_q;
        k_d    = k_q;
        if (data_valid_i) begin
            acc_d  = AW'(s_curr_q) <<< L;
            step_d = SW'(data_i) - SW'(s_curr_q);
            k_d    = '0;
        end else if (k_q != K_LAST) begin
            acc_d = acc_q + AW'(step_q);
            k_d   = k_q + L'(1);
        end
    end

    // The nominal strobe lands exactly at the last phase; anything else in RUN
    // is either early (before it) or late (missing at it).
    always_comb begin
        timing_err_d = timing_err_q
                     | (run &  data_valid_i & (k_q != K_LAST))
                     | (run & ~data_valid_i & (k_q == K_LAST));
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s_prev_q     <= '0;
            acc_q        <= '0;
            step_q       <= '0;
            k_q          <= '0;
            timing_err_q <= 1'b0;
        end else begin
            if (data_valid_i) begin
                s_prev_q <= s_curr_q;
            end
            acc_q        <= acc_d;
            step_q       <= step_d;
            k_q          <= k_d;
            timing_err_q <= timing_err_d;
        end
    end

    // acc is floor-divided by N for the 1/N interpolation weight and again by
    // N to turn a block sum back into a per-sample value.
    assign pre_y        = acc_q >>> (2 * L);
    assign timing_err_o = timing_err_q;

    // Consistency check: the running accumulator must always sit on the line
    // between the two stored samples at phase k.
    localparam int XW = AW + L + 2;
    logic signed [XW-1:0] chk_span, chk_point;
    assign chk_span  = XW'(s_curr_q) - XW'(s_prev_q);
    assign chk_point = (XW'(s_prev_q) <<< L) + $signed(XW'(k_q)) * chk_span;

    always @(posedge clk_i) begin
        if (!rst_i) begin
            assert (chk_point == XW'(acc_q));
            assert (chk_span == XW'(step_q));
        end
    end
`else
    assign pre_y        = AW'(s_curr_q) >>> L;
    assign timing_err_o = 1'b0;
`endif

    // ------------------------------------------------------- saturation
    always_comb begin
        y_sat = pre_y[OW-1:0];
        clip  = 1'b0;
        if (pre_y > Y_MAX) begin
            y_sat = Y_MAX[OW-1:0];
            clip  = 1'b1;
        end else if (pre_y < Y_MIN) begin
            y_sat = Y_MIN[OW-1:0];
            clip  = 1'b1;
        end
    end

    // ----------------------------------------------------- output stage
    // Outputs are forced to zero until the block is running so nothing from
    // a half-filled history ever appears on data_o.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            data_q       <= '0;
            data_valid_q <= 1'b0;
            sat_q        <= 1'b0;
        end else begin
            data_q       <= run ? y_sat : '0;
            data_valid_q <= run;
            sat_q        <= run & clip;
        end
    end

    assign data_o       = data_q;
    assign data_valid_o = data_valid_q;
    assign sat_o        = sat_q;

endmodule

// File: tb/tb_interpolate_upsample.sv
`timescale 1ns/1ps
module tb_interpolate_upsample;
    // Input width widened by one bit so the +/-32*9000 saturation sums fit.
    localparam int IW = 20;
    localparam int L  = 5;
    localparam int OW = 14;
    localparam int N  = 32;
    localparam longint YMAX = 8191;
    localparam longint YMIN = -8192;

`ifdef INTERP_UPSAMPLE_LINEAR_EN
    localparam bit LINEAR = 1'b1;
`else
    localparam bit LINEAR = 1'b0;
`endif
    localparam int RUN_AFTER = LINEAR ? 2 : 1;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 dvi = 1'b0;
    logic signed [IW-1:0] di  = '0;
    logic                 dvo;
    logic signed [OW-1:0] dout;
    logic                 sat;
    logic                 terr;

    always #5 clk = ~clk;

    interpolate_upsample #(
        .INPUT_WIDTH(IW),
        .LOG2_INTERP_FACTOR(L),
        .OUTPUT_WIDTH(OW)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .data_valid_i(dvi),
        .data_i(di),
        .data_valid_o(dvo),
        .data_o(dout),
        .sat_o(sat),
        .timing_err_o(terr)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // ------------------------------------------------ reference model
    // Tracks only the sample values, how many strobes have arrived and how
    // many clocks have passed since the last one.
    int     m_nvalid;
    longint m_prev, m_curr;
    int     m_since;
    bit     m_err;

    function automatic longint fdiv(input longint a, input longint b);
        longint q;
        q = a / b;
        if ((a % b) != 0 && a < 0) q = q - 1;
        return q;
    endfunction

    task automatic model_reset();
        m_nvalid = 0;
        m_prev   = 0;
        m_curr   = 0;
        m_since  = 0;
        m_err    = 1'b0;
    endtask

    task automatic model_expect(output bit dv, output longint y, output bit s);
        longint r;
        longint k;
        dv = 1'b0;
        y  = 0;
        s  = 1'b0;
        if (m_nvalid >= RUN_AFTER) begin
            k = (m_since < N - 1) ? m_since : N - 1;
            if (LINEAR) r = fdiv(m_prev * N + k * (m_curr - m_prev), N * N);
            else        r = fdiv(m_curr, N);
            dv = 1'b1;
            y  = r;
            if (r > YMAX) begin
                y = YMAX;
                s = 1'b1;
            end else if (r < YMIN) begin
                y = YMIN;
                s = 1'b1;
            end
        end
    endtask

    task automatic model_edge(input bit v, input longint d);
        bit running;
        running = (m_nvalid >= RUN_AFTER);
        if (v) begin
            if (LINEAR && running && m_since < N - 1) m_err = 1'b1;
            m_prev  = m_curr;
            m_curr  = d;
            m_since = 0;
            if (m_nvalid < RUN_AFTER) m_nvalid++;
        end else begin
            if (LINEAR && running && m_since >= N - 1) m_err = 1'b1;
            if (m_since < 1000) m_since++;
        end
    endtask

    // One clock: drive, advance model, compare every output after the edge.
    task automatic tick(input bit v, input longint d);
        bit     e_dv;
        longint e_y;
        bit     e_sat;
        model_expect(e_dv, e_y, e_sat);
        dvi = v;
        di  = d[IW-1:0];
        model_edge(v, d);
        @(posedge clk);
        #1;
        check("data_valid_o", dvo, e_dv);
        check("data_o", dout, e_y);
        check("sat_o", sat, e_sat);
        check("timing_err_o", terr, m_err);
        dvi = 1'b0;
        di  = '0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 0);
    endtask

    // Asynchronous reset pulse placed mid-cycle; outputs must clear at once.
    task automatic do_reset();
        #2;
        rst = 1'b1;
        #1;
        check("rst data_valid_o", dvo, 0);
        check("rst data_o", dout, 0);
        check("rst sat_o", sat, 0);
        check("rst timing_err_o", terr, 0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    typedef struct {
        longint s;
        longint exp_y;
        bit     exp_sat;
    } vec_t;

    vec_t tbl [12];

    initial begin
        longint d;
        int     gap;

        tbl[0]  = '{3200, 100, 1'b0};
        tbl[1]  = '{-3200, -100, 1'b0};
        tbl[2]  = '{288000, 8191, 1'b1};
        tbl[3]  = '{-288000, -8192, 1'b1};
        tbl[4]  = '{262143, 8191, 1'b0};
        tbl[5]  = '{262144, 8191, 1'b1};
        tbl[6]  = '{-262144, -8192, 1'b0};
        tbl[7]  = '{-262145, -8192, 1'b1};
        tbl[8]  = '{-1, -1, 1'b0};
        tbl[9]  = '{31, 0, 1'b0};
        tbl[10] = '{-33, -2, 1'b0};
        tbl[11] = '{0, 0, 1'b0};

        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset data_valid_o", dvo, 0);
        check("reset data_o", dout, 0);
        check("reset sat_o", sat, 0);
        check("reset timing_err_o", terr, 0);
        rst = 1'b0;

        // Constant inputs: each value is sent twice on the nominal period so
        // both modes settle to floor(S/32).
        for (int i = 0; i < 12; i++) begin
            tick(1'b1, tbl[i].s);
            idle(31);
            tick(1'b1, tbl[i].s);
            idle(3);
            check("vec data_o", dout, tbl[i].exp_y);
            check("vec sat_o", sat, tbl[i].exp_sat);
            $display("vec %0d: S=%0d data_o=%0d sat_o=%0d", i, tbl[i].s, dout, sat);
            idle(28);
        end

        // Ramp 3200 -> 5248 -> 7296 on the nominal period.
        do_reset();
        tick(1'b1, 3200);
        idle(31);
        tick(1'b1, 5248);
        for (int i = 0; i < 32; i++) begin
            if (i < 31) tick(1'b0, 0);
            else        tick(1'b1, 7296);
            check("ramp data_o", dout, LINEAR ? 100 + 2 * i : 164);
        end
        $display("ramp: last data_o=%0d timing_err_o=%0d", dout, terr);

        // Late: strobe withheld for 40 cycles.
        idle(40);
        check("late data_o", dout, LINEAR ? 226 : 228);
        check("late timing_err_o", terr, LINEAR ? 1 : 0);
        $display("late: data_o=%0d timing_err_o=%0d", dout, terr);

        // Early: third strobe only 20 cycles after the second.
        do_reset();
        tick(1'b1, 3200);
        idle(31);
        tick(1'b1, 5248);
        idle(19);
        tick(1'b1, 1600);
        tick(1'b0, 0);
        check("early data_o", dout, LINEAR ? 164 : 50);
        check("early timing_err_o", terr, LINEAR ? 1 : 0);
        $display("early: data_o=%0d timing_err_o=%0d", dout, terr);

        // Reset mid-RUN, then count strobes needed to restart.
        do_reset();
        tick(1'b1, 6400);
        idle(2);
        check("restart1 data_valid_o", dvo, LINEAR ? 0 : 1);
        check("restart1 data_o", dout, LINEAR ? 0 : 200);
        idle(29);
        tick(1'b1, 6400);
        tick(1'b0, 0);
        check("restart2 data_valid_o", dvo, 1);
        check("restart2 data_o", dout, 200);
        $display("restart: data_valid_o=%0d data_o=%0d", dvo, dout);

        // Random bursts with mostly nominal and occasionally early/late timing.
        for (int b = 0; b < 6; b++) begin
            do_reset();
            for (int v = 0; v < 40; v++) begin
                d   = longint'($urandom_range(0, (1 << IW) - 1)) - (longint'(1) << (IW - 1));
                gap = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 45)) : 31;
                tick(1'b1, d);
                idle(gap);
            end
            $display("random burst %0d: timing_err_o=%0d compared=%0d", b, terr, n_cmp);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/interpolate_upsample.md
INTERPOLATE_UPSAMPLE -- requirements
Module: interpolate_upsample

Interface
REQ-001 The block SHALL have parameter INPUT_WIDTH, default 19: signed width of incoming decimated block sums.
REQ-002 The block SHALL have parameter LOG2_INTERP_FACTOR, default 5: N = 2**LOG2_INTERP_FACTOR, the output samples per input sample.
REQ-003 The block SHALL have parameter OUTPUT_WIDTH, default 14: signed width of the full-rate output.
REQ-004 The block SHALL have port clk_i, input, 1 bit: the single clock; all logic is rising-edge.
REQ-005 The block SHALL have port rst_i, input, 1 bit: asynchronous, active-high reset.
REQ-006 The block SHALL have port data_valid_i, input, 1 bit: one-cycle strobe qualifying data_i.
REQ-007 The block SHALL have port data_i, input, INPUT_WIDTH bits: signed sum of N raw samples (S).
REQ-008 The block SHALL have port data_valid_o, output, 1 bit: high on every cycle data_o is meaningful.
REQ-009 The block SHALL have port data_o, output, OUTPUT_WIDTH bits: signed, registered, full-rate output.
REQ-010 The block SHALL have port sat_o, output, 1 bit: high in the same cycle as a data_o value that was clipped.
REQ-011 The block SHALL have port timing_err_o, output, 1 bit: sticky, set on an early or late data_valid_i.

Function
REQ-012 The block SHALL hold S_prev and S_curr; on data_valid_i, S_prev <= S_curr and S_curr <= data_i.
REQ-013 The FSM SHALL have states EMPTY, PRIMED, RUN: EMPTY->PRIMED on the first valid, PRIMED->RUN on the second valid, RUN holds until reset.
REQ-014 On each valid, the block SHALL load acc <= S_curr(old) * N and step <= data_i - S_curr(old), and SHALL clear phase counter k to 0.
REQ-015 On non-valid cycles with k < N-1, the block SHALL apply acc <= acc + step and k <= k + 1.
REQ-016 acc SHALL be INPUT_WIDTH+LOG2_INTERP_FACTOR+1 bits and step SHALL be INPUT_WIDTH+1 bits, both signed, with no internal overflow.
REQ-017 y SHALL be acc arithmetic-shifted right by 2*LOG2_INTERP_FACTOR (floor), then saturated to OUTPUT_WIDTH signed range, with sat_o=1 when clipped.
REQ-018 data_o/data_valid_o/sat_o SHALL be registered from acc: a valid at cycle t produces y_0 = floor(S_prev/N) at cycle t+2.
REQ-019 data_valid_o SHALL be 1 on every cycle from the first output of RUN onward, and 0 in EMPTY/PRIMED.
REQ-020 Late input: at k = N-1 with no valid, acc and k SHALL hold (data_o repeats, no extrapolation) and timing_err_o SHALL set.
REQ-021 Early input: a valid while k < N-1 in RUN SHALL restart per REQ-014 immediately and timing_err_o SHALL set.
REQ-022 A valid exactly at k = N-1 SHALL be nominal, with no error.
REQ-023 A valid in EMPTY/PRIMED SHALL never set timing_err_o.

Reset
REQ-024 rst_i SHALL asynchronously force state=EMPTY, S_prev=S_curr=acc=step=k=0, data_o=0, data_valid_o=0, sat_o=0, timing_err_o=0.
REQ-025 Reset asserted mid-RUN SHALL discard all history; after release, two new valids are needed before data_valid_o rises.

Configuration
REQ-026 Macro INTERP_UPSAMPLE_LINEAR_EN SHALL select the interpolation mode.
REQ-027 With INTERP_UPSAMPLE_LINEAR_EN defined, the block SHALL behave as REQ-012..REQ-025 (linear interpolation).
REQ-028 Without INTERP_UPSAMPLE_LINEAR_EN, the block SHALL be zero-order hold: acc/step/k SHALL be removed, y = floor(S_curr/N) saturated, updated at t+2 after each valid.
REQ-029 In zero-order-hold mode, PRIMED SHALL be skipped (EMPTY->RUN on the first valid) and timing_err_o SHALL be tied 0.

Verification (defaults, N=32, linear unless noted)
REQ-030 Ramp: valids every 32 cycles with S=3200 then 5248 -> data_o=100,102,...,162 on consecutive cycles, data_valid_o=1, timing_err_o=0.
REQ-031 Constant: S=-3200 repeated every 32 cycles -> data_o=-100 every cycle in RUN, with no sat_o.
REQ-032 Late: valid withheld 40 cycles -> data_o holds at y_31 for 8 cycles and timing_err_o=1 (sticky).
REQ-033 Early: valid after 20 cycles -> data_o jumps to new y_0 at t+2 and timing_err_o=1.
REQ-034 Saturation: S=32*9000 -> data_o=8191, sat_o=1; S=-32*9000 -> data_o=-8192, sat_o=1.
REQ-035 Reset mid-RUN pulse -> all outputs 0 asynchronously; data_valid_o stays 0 until two valids follow (one valid in zero-order-hold mode, which SHALL output floor(S/32)).
